// File: rtl/if_id_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS core.
// Owns the PC, handles hazard stalls and taken branch/jump redirects, and slices the decode fields.
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic             id_valid,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_pc4,
  output logic [31:0]      id_instr,
  output logic [5:0]       id_op,
  output logic [4:0]       id_rs,
  output logic [4:0]       id_rt,
  output logic [4:0]       id_rd,
  output logic [4:0]       id_shamt,
  output logic [5:0]       id_funct,
  output logic [15:0]      id_imm16,
  output logic [25:0]      id_target26,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] squash_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [31:0] pc_p0;

  assign imem_addr = pc_p0;

  // IF -> IF/ID boundary; a redirect squashes the wrong-path word even while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p0    <= RESET_PC;
      id_valid <= 1'b0;
      id_instr <= 32'h0;
      id_pc    <= 32'h0;
    end else if (redirect_valid) begin
      pc_p0    <= redirect_pc & ~32'h3;
      id_valid <= 1'b0;
      id_instr <= 32'h0;
      id_pc    <= 32'h0;
    end else if (!stall) begin
      pc_p0    <= pc_p0 + 32'd4;
      id_valid <= 1'b1;
      id_instr <= imem_rdata;
      id_pc    <= pc_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      squash_cnt <= '0;
    end else if (redirect_valid) begin
      squash_cnt <= sat_inc(squash_cnt);
    end else if (stall) begin
      stall_cnt  <= sat_inc(stall_cnt);
    end
  end

  assign id_pc4      = id_pc + 32'd4;
  assign id_op       = id_instr[31:26];
  assign id_rs       = id_instr[25:21];
  assign id_rt       = id_instr[20:16];
  assign id_rd       = id_instr[15:11];
  assign id_shamt    = id_instr[10:6];
  assign id_funct    = id_instr[5:0];
  assign id_imm16    = id_instr[15:0];
  assign id_target26 = id_instr[25:0];

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: reset, fetch, stall, redirect, field slicing, wrap and saturation.
module tb_if_id_stage;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = 32'h0;
  logic [31:0]   imem_addr, imem_rdata;
  logic          id_valid;
  logic [31:0]   id_pc, id_pc4, id_instr;
  logic [5:0]    id_op, id_funct;
  logic [4:0]    id_rs, id_rt, id_rd, id_shamt;
  logic [15:0]   id_imm16;
  logic [25:0]   id_target26;
  logic [CW-1:0] stall_cnt, squash_cnt;
  logic          mem_force = 1'b0;
  logic [31:0]   mem_force_val = 32'h0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // imem[i] = 0x1000 + i for byte address 0x3000 + 4*i
  assign imem_rdata = mem_force ? mem_force_val : 32'h1000 + ((imem_addr - 32'h3000) >> 2);

  if_id_stage #(.RESET_PC(32'h0000_3000), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_pc(id_pc), .id_pc4(id_pc4), .id_instr(id_instr),
    .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
    .id_funct(id_funct), .id_imm16(id_imm16), .id_target26(id_target26),
    .stall_cnt(stall_cnt), .squash_cnt(squash_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (imem_addr !== 32'h3000) begin errors++; $display("FAIL rst_addr got %h want %h", imem_addr, 32'h3000); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", id_valid); end
    checks++; if (id_instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h want 0", id_instr); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want 0", id_pc); end
    checks++; if (stall_cnt !== 3'd0 || squash_cnt !== 3'd0) begin errors++; $display("FAIL rst_cnt got %0d/%0d want 0/0", stall_cnt, squash_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL fetch_valid[%0d] got %b want 1", i, id_valid); end
      checks++; if (id_instr !== 32'h1000 + 32'(i)) begin errors++; $display("FAIL fetch_instr[%0d] got %h want %h", i, id_instr, 32'h1000 + 32'(i)); end
      checks++; if (id_pc !== 32'h3000 + 32'(4 * i)) begin errors++; $display("FAIL fetch_pc[%0d] got %h want %h", i, id_pc, 32'h3000 + 32'(4 * i)); end
      checks++; if (id_pc4 !== 32'h3004 + 32'(4 * i)) begin errors++; $display("FAIL fetch_pc4[%0d] got %h want %h", i, id_pc4, 32'h3004 + 32'(4 * i)); end
      checks++; if (imem_addr !== 32'h3004 + 32'(4 * i)) begin errors++; $display("FAIL fetch_addr[%0d] got %h want %h", i, imem_addr, 32'h3004 + 32'(4 * i)); end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (id_pc !== 32'h3008 || id_instr !== 32'h1002) begin errors++; $display("FAIL stall_hold[%0d] got %h/%h want 00003008/00001002", i, id_pc, id_instr); end
      checks++; if (imem_addr !== 32'h300C) begin errors++; $display("FAIL stall_addr[%0d] got %h want 0000300c", i, imem_addr); end
    end
    stall = 1'b0;
    checks++; if (stall_cnt !== 3'd3) begin errors++; $display("FAIL stall_cnt got %0d want 3", stall_cnt); end
    step();
    checks++; if (id_pc !== 32'h300C || id_instr !== 32'h1003) begin errors++; $display("FAIL stall_resume got %h/%h want 0000300c/00001003", id_pc, id_instr); end
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1;
    redirect_pc = 32'h3100;
    step();
    redirect_valid = 1'b0;
    checks++; if (imem_addr !== 32'h3100) begin errors++; $display("FAIL redir_addr got %h want 00003100", imem_addr); end
    checks++; if (id_valid !== 1'b0 || id_instr !== 32'h0 || id_pc !== 32'h0) begin errors++; $display("FAIL redir_bubble got %b/%h/%h want 0/0/0", id_valid, id_instr, id_pc); end
    checks++; if (squash_cnt !== 3'd1) begin errors++; $display("FAIL redir_squash got %0d want 1", squash_cnt); end
    step();
    checks++; if (id_pc !== 32'h3100 || id_instr !== 32'h1040 || id_valid !== 1'b1) begin errors++; $display("FAIL redir_target got %h/%h/%b want 00003100/00001040/1", id_pc, id_instr, id_valid); end
  endtask

  task automatic test_stall_redirect();
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h3203;
    step();
    stall = 1'b0;
    redirect_valid = 1'b0;
    checks++; if (imem_addr !== 32'h3200) begin errors++; $display("FAIL sr_addr got %h want 00003200", imem_addr); end
    checks++; if (id_valid !== 1'b0 || id_instr !== 32'h0) begin errors++; $display("FAIL sr_bubble got %b/%h want 0/0", id_valid, id_instr); end
    checks++; if (squash_cnt !== 3'd2 || stall_cnt !== 3'd3) begin errors++; $display("FAIL sr_cnt got %0d/%0d want 2/3", squash_cnt, stall_cnt); end
    step();
    checks++; if (id_pc !== 32'h3200 || id_instr !== 32'h1080) begin errors++; $display("FAIL sr_target got %h/%h want 00003200/00001080", id_pc, id_instr); end
  endtask

  task automatic test_fields();
    mem_force = 1'b1;
    mem_force_val = 32'h8D2A_5B67;
    step();
    mem_force = 1'b0;
    checks++; if (id_op !== 6'h23 || id_funct !== 6'h27) begin errors++; $display("FAIL fld_op_funct got %h/%h want 23/27", id_op, id_funct); end
    checks++; if (id_rs !== 5'd9 || id_rt !== 5'd10 || id_rd !== 5'd11 || id_shamt !== 5'd13) begin errors++; $display("FAIL fld_regs got %0d/%0d/%0d/%0d want 9/10/11/13", id_rs, id_rt, id_rd, id_shamt); end
    checks++; if (id_imm16 !== 16'h5B67 || id_target26 !== 26'h12A5B67) begin errors++; $display("FAIL fld_imm got %h/%h want 5b67/12a5b67", id_imm16, id_target26); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr0 got %h want fffffffc", imem_addr); end
    step();
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h want 0", imem_addr); end
    checks++; if (id_pc !== 32'hFFFF_FFFC || id_pc4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got %h/%h want fffffffc/0", id_pc, id_pc4); end
  endtask

  task automatic test_saturate();
    stall = 1'b1;
    for (int i = 0; i < 6; i++) step();
    checks++; if (stall_cnt !== 3'd7) begin errors++; $display("FAIL sat_cnt got %0d want 7", stall_cnt); end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    step();
    checks++; if (imem_addr !== 32'h3000 || id_valid !== 1'b0 || id_instr !== 32'h0) begin errors++; $display("FAIL mid_rst got %h/%b/%h want 00003000/0/0", imem_addr, id_valid, id_instr); end
    checks++; if (stall_cnt !== 3'd0 || squash_cnt !== 3'd0) begin errors++; $display("FAIL mid_cnt got %0d/%0d want 0/0", stall_cnt, squash_cnt); end
    rst = 1'b0;
    stall = 1'b0;
    step();
    checks++; if (id_pc !== 32'h3000 || id_instr !== 32'h1000 || id_valid !== 1'b1) begin errors++; $display("FAIL mid_restart got %h/%h/%b want 00003000/00001000/1", id_pc, id_instr, id_valid); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_redirect();
    test_stall_redirect();
    test_fields();
    test_wrap();
    test_saturate();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
